// File: rtl/calendar_pkg.sv
// ============================================================================
// Module : calendar_pkg
// Brief  : Shared encodings, BCD constants and calendar helper functions for
//          the BCD time-of-day / calendar counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package calendar_pkg;

  // Field select encodings for set mode; 6 and 7 select nothing.
  typedef enum logic [2:0] {
    SEL_SEC   = 3'd0,
    SEL_MIN   = 3'd1,
    SEL_HOUR  = 3'd2,
    SEL_DAY   = 3'd3,
    SEL_MONTH = 3'd4,
    SEL_YEAR  = 3'd5,
    SEL_NONE6 = 3'd6,
    SEL_NONE7 = 3'd7
  } field_sel_e;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  // Two-digit BCD divisible-by-4 test: (10*t + o) % 4 == (2*t[0] + o) % 4,
  // so only tens[0] and ones[1:0] matter.
  function automatic logic bcd2_div4(input logic [7:0] v);
    logic [1:0] s;
    s = {v[4], 1'b0} + v[1:0];
    return (s == 2'd0);
  endfunction

  function automatic logic is_leap(input logic [15:0] yyyy_bcd);
    logic [7:0] yy;
    logic [7:0] cc;
    yy = yyyy_bcd[7:0];
    cc = yyyy_bcd[15:8];
    return ((yy != BCD_00) && bcd2_div4(yy)) || ((yy == BCD_00) && bcd2_div4(cc));
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] mm_bcd,
                                               input logic [15:0] yyyy_bcd);
    logic [7:0] d;
    case (mm_bcd)
      8'h04, 8'h06, 8'h09, 8'h11: d = 8'h30;
      8'h02:                      d = is_leap(yyyy_bcd) ? 8'h29 : 8'h28;
      default:                    d = 8'h31;
    endcase
    return d;
  endfunction

  // Two-digit BCD increment; values at or above max wrap to min.
  function automatic logic [7:0] bcd2_inc_wrap(input logic [7:0] v,
                                               input logic [7:0] max_v,
                                               input logic [7:0] min_v);
    logic [7:0] r;
    if (v >= max_v)
      r = min_v;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Four-digit BCD increment, 9999 wraps to 0000.
  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // 24h BCD hour to 12h BCD hour (00 -> 12, 13..23 -> 01..11).
  function automatic logic [7:0] hour_to_12(input logic [7:0] h);
    logic [7:0] r;
    if (h == BCD_00)
      r = BCD_12;
    else if (h <= BCD_12)
      r = h;
    else if (h[7:4] == 4'd1)
      r = {4'd0, h[3:0] - 4'd2};
    else if (h[3:0] < 4'd2)
      r = {4'd0, h[3:0] + 4'd8};
    else
      r = {4'd1, h[3:0] - 4'd2};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/calendar_time_counter_bcd2_wrap_counter.sv
// ============================================================================
// Module : bcd2_wrap_counter
// Brief  : Two-digit BCD register with synchronous load, increment, runtime
//          wrap bounds and a carry-out.
// Ports  : clk, rst_n        clock, synchronous active-low reset
//          load_i/load_val_i synchronous load (priority over inc)
//          inc_i             increment by one
//          wrap_max_i/min_i  on inc at/above max the value becomes min
//          q_o               registered value
//          carry_o           inc_i while at/above max (wrap this edge)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd2_wrap_counter
  import calendar_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       inc_i,
  input  logic [7:0] wrap_max_i,
  input  logic [7:0] wrap_min_i,
  output logic [7:0] q_o,
  output logic       carry_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign carry_o = inc_i && (cnt_q >= wrap_max_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (inc_i)
      cnt_d = bcd2_inc_wrap(cnt_q, wrap_max_i, wrap_min_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= RST_VAL;
    else
      cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/calendar_time_counter.sv
// ============================================================================
// Module : calendar_time_counter
// Brief  : Free-running BCD time-of-day + calendar (ss mm hh DD MM YYYY) with
//          leap-year rule, set mode for field editing and a 12h view.
// Ports  : clk       system clock
//          rst_n     synchronous active-low reset
//          tick      1-cycle pulse: advance one second (ignored in set mode)
//          set_en    set mode enable
//          set_sel   field select 0 sec .. 5 year, 6/7 none
//          set_inc   1-cycle pulse: edit selected field (set mode only)
//          digits    14 BCD nibbles, nibble 0 = seconds LSD, top = year MSD
//          hour12    BCD hour 01..12
//          pm        hour24 >= 12
//          day_wrap  1-cycle pulse when 23:59:59 rolls to 00:00:00
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module calendar_time_counter
  import calendar_pkg::*;
#(
  parameter logic [15:0] RST_YEAR  = 16'h2000,
  parameter logic [7:0]  RST_MONTH = 8'h01,
  parameter logic [7:0]  RST_DAY   = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        set_en,
  input  logic [2:0]  set_sel,
  input  logic        set_inc,
  output logic [55:0] digits,
  output logic [7:0]  hour12,
  output logic        pm,
  output logic        day_wrap
);

  logic run;
  logic edit;
  assign run  = tick & ~set_en;
  assign edit = set_en & set_inc;

  logic [7:0]  sec_q, min_q, hour_q, day_q, month_q;
  logic [15:0] year_q, year_d;
  logic        sec_c, min_c, hour_c, day_c, month_c;
  logic        min_inc, hour_inc, day_inc, month_inc, year_inc;
  logic        day_wrap_q, day_wrap_d;

  // Carries only ripple in run mode; edits touch exactly one field.
  assign min_inc   = (run & sec_c)   | (edit & (set_sel == SEL_MIN));
  assign hour_inc  = (run & min_c)   | (edit & (set_sel == SEL_HOUR));
  assign day_inc   = (run & hour_c)  | (edit & (set_sel == SEL_DAY));
  assign month_inc = (run & day_c)   | (edit & (set_sel == SEL_MONTH));
  assign year_inc  = (run & month_c) | (edit & (set_sel == SEL_YEAR));

  logic [7:0] dim_cur;
  assign dim_cur = days_in_month(month_q, year_q);

  // Day clamp uses the month/year values being written this same edge.
  logic [7:0] month_next;
  logic [7:0] dim_new;
  logic       day_clamp;
  assign month_next = month_inc ? bcd2_inc_wrap(month_q, BCD_12, BCD_01) : month_q;
  assign year_d     = year_inc ? bcd4_inc(year_q) : year_q;
  assign dim_new    = days_in_month(month_next, year_d);
  assign day_clamp  = edit & ((set_sel == SEL_MONTH) | (set_sel == SEL_YEAR))
                    & (day_q > dim_new);

  bcd2_wrap_counter #(.RST_VAL(BCD_00)) u_sec (
    .clk(clk), .rst_n(rst_n),
    .load_i(edit & (set_sel == SEL_SEC)), .load_val_i(BCD_00),
    .inc_i(run), .wrap_max_i(BCD_59), .wrap_min_i(BCD_00),
    .q_o(sec_q), .carry_o(sec_c)
  );

  bcd2_wrap_counter #(.RST_VAL(BCD_00)) u_min (
    .clk(clk), .rst_n(rst_n),
    .load_i(1'b0), .load_val_i(BCD_00),
    .inc_i(min_inc), .wrap_max_i(BCD_59), .wrap_min_i(BCD_00),
    .q_o(min_q), .carry_o(min_c)
  );

  bcd2_wrap_counter #(.RST_VAL(BCD_00)) u_hour (
    .clk(clk), .rst_n(rst_n),
    .load_i(1'b0), .load_val_i(BCD_00),
    .inc_i(hour_inc), .wrap_max_i(BCD_23), .wrap_min_i(BCD_00),
    .q_o(hour_q), .carry_o(hour_c)
  );

  bcd2_wrap_counter #(.RST_VAL(RST_DAY)) u_day (
    .clk(clk), .rst_n(rst_n),
    .load_i(day_clamp), .load_val_i(dim_new),
    .inc_i(day_inc), .wrap_max_i(dim_cur), .wrap_min_i(BCD_01),
    .q_o(day_q), .carry_o(day_c)
  );

  bcd2_wrap_counter #(.RST_VAL(RST_MONTH)) u_month (
    .clk(clk), .rst_n(rst_n),
    .load_i(1'b0), .load_val_i(BCD_00),
    .inc_i(month_inc), .wrap_max_i(BCD_12), .wrap_min_i(BCD_01),
    .q_o(month_q), .carry_o(month_c)
  );

  // hour carry in run mode only happens from 23:59:59.
  assign day_wrap_d = run & hour_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      year_q     <= RST_YEAR;
      day_wrap_q <= 1'b0;
    end else begin
      year_q     <= year_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign digits   = {year_q, month_q, day_q, hour_q, min_q, sec_q};
  assign hour12   = hour_to_12(hour_q);
  assign pm       = (hour_q >= BCD_12);
  assign day_wrap = day_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_calendar_time_counter.sv
// ============================================================================
// Module : tb_calendar_time_counter
// Brief  : Directed, table-driven self-checking bench for calendar_time_counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_calendar_time_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        set_en;
  logic [2:0]  set_sel;
  logic        set_inc;
  logic [55:0] digits;
  logic [7:0]  hour12;
  logic        pm;
  logic        day_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  calendar_time_counter dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_en(set_en),
    .set_sel(set_sel), .set_inc(set_inc), .digits(digits),
    .hour12(hour12), .pm(pm), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] yr;
    logic [7:0]  mo;
    logic [7:0]  dy;
    logic [55:0] exp_digits;
  } roll_vec_t;

  typedef struct {
    logic [7:0] h24;
    logic [7:0] h12;
    logic       pm;
  } hour_vec_t;

  roll_vec_t rv[6];
  hour_vec_t hv[8];

  localparam logic [55:0] RESET_DIGITS = 56'h2000_0101_000000;

  task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; set_en = 1'b0; set_inc = 1'b0; set_sel = 3'd0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_inc(input logic [2:0] sel);
    set_sel = sel; set_inc = 1'b1;
    step();
    set_inc = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  function automatic logic [15:0] field(input logic [2:0] sel);
    case (sel)
      3'd0:    return {8'h00, digits[7:0]};
      3'd1:    return {8'h00, digits[15:8]};
      3'd2:    return {8'h00, digits[23:16]};
      3'd3:    return {8'h00, digits[31:24]};
      3'd4:    return {8'h00, digits[39:32]};
      default: return digits[55:40];
    endcase
  endfunction

  // Step the selected field in set mode until it reads val (bounded).
  task automatic set_field(input logic [2:0] sel, input logic [15:0] val);
    int n;
    n = 0;
    while (field(sel) != val && n < 10000) begin
      pulse_inc(sel);
      n++;
    end
    check("set_field_reach", 56'(field(sel)), 56'(val));
  endtask

  task automatic set_datetime(input logic [15:0] yr, input logic [7:0] mo,
                              input logic [7:0] dy, input logic [7:0] hh,
                              input logic [7:0] mi);
    set_en = 1'b1;
    set_field(3'd5, yr);
    set_field(3'd4, {8'h00, mo});
    set_field(3'd3, {8'h00, dy});
    set_field(3'd2, {8'h00, hh});
    set_field(3'd1, {8'h00, mi});
    set_field(3'd0, 16'h0000);
    set_en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rv[0] = '{16'h2023, 8'h12, 8'h31, 56'h2024_0101_000000};
    rv[1] = '{16'h2024, 8'h02, 8'h28, 56'h2024_0229_000000};
    rv[2] = '{16'h2023, 8'h02, 8'h28, 56'h2023_0301_000000};
    rv[3] = '{16'h2100, 8'h02, 8'h28, 56'h2100_0301_000000};
    rv[4] = '{16'h2000, 8'h02, 8'h28, 56'h2000_0229_000000};
    rv[5] = '{16'h2024, 8'h02, 8'h29, 56'h2024_0301_000000};

    hv[0] = '{8'h00, 8'h12, 1'b0};
    hv[1] = '{8'h11, 8'h11, 1'b0};
    hv[2] = '{8'h12, 8'h12, 1'b1};
    hv[3] = '{8'h13, 8'h01, 1'b1};
    hv[4] = '{8'h19, 8'h07, 1'b1};
    hv[5] = '{8'h20, 8'h08, 1'b1};
    hv[6] = '{8'h22, 8'h10, 1'b1};
    hv[7] = '{8'h23, 8'h11, 1'b1};

    // Reset state
    do_reset();
    check("reset_digits", digits, RESET_DIGITS);
    check("reset_hour12", 56'(hour12), 56'h12);
    check("reset_pm", 56'(pm), 56'h0);
    check("reset_day_wrap", 56'(day_wrap), 56'h0);

    // Rollover table: from Y-M-D 23:59:59, one tick
    for (int i = 0; i < 6; i++) begin
      do_reset();
      set_datetime(rv[i].yr, rv[i].mo, rv[i].dy, 8'h23, 8'h59);
      tick_n(59);
      check($sformatf("roll%0d_pre", i), digits,
            {rv[i].yr, rv[i].mo, rv[i].dy, 24'h235959});
      check($sformatf("roll%0d_no_wrap_yet", i), 56'(day_wrap), 56'h0);
      tick_n(1);
      check($sformatf("roll%0d_digits", i), digits, rv[i].exp_digits);
      check($sformatf("roll%0d_wrap_hi", i), 56'(day_wrap), 56'h1);
      step();
      check($sformatf("roll%0d_wrap_lo", i), 56'(day_wrap), 56'h0);
    end

    // Set mode: tick frozen, clamps, no carries between fields
    do_reset();
    set_en = 1'b1;
    set_field(3'd5, 16'h2024);
    set_field(3'd3, 16'h0031);
    tick = 1'b1; step(); step(); step(); tick = 1'b0;
    check("set_tick_ignored", digits, 56'h2024_0131_000000);
    check("set_no_wrap", 56'(day_wrap), 56'h0);
    pulse_inc(3'd4);
    check("set_month_clamp", digits, 56'h2024_0229_000000);
    pulse_inc(3'd5);
    check("set_year_clamp", digits, 56'h2025_0228_000000);
    set_field(3'd2, 16'h0005);
    set_field(3'd1, 16'h0059);
    pulse_inc(3'd1);
    check("set_min_wrap", digits, 56'h2025_0228_050000);
    pulse_inc(3'd6);
    pulse_inc(3'd7);
    check("set_sel_none", digits, 56'h2025_0228_050000);
    pulse_inc(3'd3);
    check("set_day_wrap_nocarry", digits, 56'h2025_0201_050000);
    set_en = 1'b0;
    tick_n(1);
    check("resume_tick", digits, 56'h2025_0201_050001);
    set_en = 1'b1;
    pulse_inc(3'd0);
    check("set_sec_clear", digits, 56'h2025_0201_050000);

    // 12h mapping table
    for (int i = 0; i < 8; i++) begin
      set_field(3'd2, {8'h00, hv[i].h24});
      check($sformatf("h12_%h", hv[i].h24), 56'(hour12), 56'(hv[i].h12));
      check($sformatf("pm_%h", hv[i].h24), 56'(pm), 56'(hv[i].pm));
    end
    set_en = 1'b0;

    // Reset beats a wrapping tick
    do_reset();
    set_datetime(16'h2000, 8'h01, 8'h01, 8'h23, 8'h59);
    tick_n(59);
    rst_n = 1'b0; tick = 1'b1;
    step();
    rst_n = 1'b1; tick = 1'b0;
    check("rst_vs_tick_digits", digits, RESET_DIGITS);
    check("rst_vs_tick_wrap", 56'(day_wrap), 56'h0);

    // Reset beats tick, set_en and set_inc together
    set_datetime(16'h2000, 8'h01, 8'h01, 8'h23, 8'h59);
    tick_n(59);
    rst_n = 1'b0; tick = 1'b1; set_en = 1'b1; set_inc = 1'b1; set_sel = 3'd5;
    step();
    rst_n = 1'b1; tick = 1'b0; set_en = 1'b0; set_inc = 1'b0;
    check("rst_all_digits", digits, RESET_DIGITS);
    check("rst_all_wrap", 56'(day_wrap), 56'h0);
    check("rst_all_hour12", 56'(hour12), 56'h12);
    check("rst_all_pm", 56'(pm), 56'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
